alsu_accumulator_ctrl: RTL and testbench

- Command-issue and writeback stage wrapped around the 4-bit combinational arithmetic_logic_shift_unit.
- Accepts operation commands over a valid/ready handshake and registers the operands onto the ALSU inputs.
- Captures F/Cout into an accumulator and a 2-entry in-order result buffer.
- Lets a sequencer chain operations through the accumulator without external feedback.

---
 rtl/alsu_accumulator_ctrl_if.sv | 55 +++++
 rtl/alsu_accumulator_ctrl.sv | 131 +++++++++++++
 tb/tb_alsu_accumulator_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alsu_accumulator_ctrl_if.sv
// Command / ALSU / result bundle for alsu_accumulator_ctrl.
//   master : sequencer plus the combinational ALSU (drives cmd_*, alu_f/alu_cout, res_ready)
//   slave  : the controller (drives cmd_ready, alu_a/b/cin/s, res_*, acc)
// Signals:
//   cmd_valid/cmd_ready, cmd_op[3:0], cmd_a, cmd_b, cmd_cin, cmd_src_acc : command handshake
//   alu_a, alu_b, alu_cin, alu_s[3:0] : registered ALSU inputs
//   alu_f, alu_cout                   : ALSU outputs
//   res_valid/res_ready, res_data, res_cout, res_zero : result buffer head
//   acc                               : current accumulator
interface alsu_accumulator_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_cin;
    logic             cmd_src_acc;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_f;
    logic             alu_cout;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_cout;
    logic             res_zero;

    logic [WIDTH-1:0] acc;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_src_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_cin, alu_s,
        output alu_f, alu_cout,
        input  res_valid, res_data, res_cout, res_zero,
        output res_ready,
        input  acc
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_src_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_cin, alu_s,
        input  alu_f, alu_cout,
        output res_valid, res_data, res_cout, res_zero,
        input  res_ready,
        output acc
    );
endinterface

// File: rtl/alsu_accumulator_ctrl.sv
// Command-issue and writeback stage around the 4-bit combinational ALSU.
// A command is registered onto the ALSU inputs on accept (IDLE), the ALSU settles for one
// full cycle (EXEC), and its F/Cout is captured into the accumulator and an in-order result
// FIFO. Ops 1110 (CLR) and 1111 (READ) are handled internally and ignore the ALSU output.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alsu_accumulator_ctrl_if.slave (command, ALSU, result and accumulator signals)
module alsu_accumulator_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input logic                     clk,
    input logic                     rst,
    alsu_accumulator_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);
    localparam logic [3:0]  OpClr  = 4'b1110;
    localparam logic [3:0]  OpRead = 4'b1111;

    if (WIDTH != 4 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
        $error("alsu_accumulator_ctrl: WIDTH must be 4 and DEPTH a power of 2 >= 2");
    end

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_cin_q;
    logic [3:0]       alu_s_q;

    logic [WIDTH-1:0] buf_data_q [DEPTH];
    logic             buf_cout_q [DEPTH];
    logic             buf_zero_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] exec_data;
    logic             exec_cout;
    logic [WIDTH-1:0] exec_acc;

    // Only one command is ever in flight, so checking free space at accept is enough to
    // guarantee the EXEC push always has room.
    assign bus.cmd_ready = !rst && (state_q == StIdle) && (count_q < CountFull);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign push          = (state_q == StExec);
    assign pop           = bus.res_valid && bus.res_ready;

    // alu_s_q doubles as the registered op code.
    always_comb begin
        exec_data = bus.alu_f;
        exec_cout = bus.alu_cout;
        exec_acc  = bus.alu_f;
        if (alu_s_q == OpClr) begin
            exec_data = '0;
            exec_cout = 1'b0;
            exec_acc  = '0;
        end else if (alu_s_q == OpRead) begin
            exec_data = acc_q;
            exec_cout = 1'b0;
            exec_acc  = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_cin_q <= 1'b0;
            alu_s_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_data_q[i] <= '0;
                buf_cout_q[i] <= 1'b0;
                buf_zero_q[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        alu_a_q   <= bus.cmd_src_acc ? acc_q : bus.cmd_a;
                        alu_b_q   <= bus.cmd_b;
                        alu_cin_q <= bus.cmd_cin;
                        alu_s_q   <= bus.cmd_op;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    buf_data_q[wr_ptr_q] <= exec_data;
                    buf_cout_q[wr_ptr_q] <= exec_cout;
                    buf_zero_q[wr_ptr_q] <= (exec_data == '0);
                    wr_ptr_q             <= wr_ptr_q + 1'b1;
                    acc_q                <= exec_acc;
                    state_q              <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_cin   = alu_cin_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.acc       = acc_q;
    assign bus.res_valid = (count_q != '0);
    assign bus.res_data  = buf_data_q[rd_ptr_q];
    assign bus.res_cout  = buf_cout_q[rd_ptr_q];
    assign bus.res_zero  = buf_zero_q[rd_ptr_q];
endmodule

// File: tb/tb_alsu_accumulator_ctrl.sv
// Self-checking bench for alsu_accumulator_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level model (FIFO of expected results, latency counter).
module tb_alsu_accumulator_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_f = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    alsu_accumulator_ctrl_if #(.WIDTH(4)) bus ();

    alsu_accumulator_ctrl #(.WIDTH(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALSU: {cout, f}. Codes 1110/1111 return junk so ignoring it is observable.
    function automatic logic [4:0] alsu(input logic [3:0] s, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
        case (s)
            4'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
            4'd1:    return {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
            4'd2:    return {1'b0, a} + 5'h0F + {4'b0, cin};
            4'd3:    return {1'b0, a} + {4'b0, cin};
            4'd4:    return {1'b0, a} + {1'b0, b} + 5'd1;
            4'd5:    return {1'b0, a} + 5'd1;
            4'd6:    return {1'b0, a & b};
            4'd7:    return {1'b0, a | b};
            4'd8:    return {1'b0, a ^ b};
            4'd9:    return {1'b0, ~a};
            4'd10:   return {a[3], a[2:0], 1'b0};
            4'd11:   return {a[0], 1'b0, a[3:1]};
            4'd12:   return {1'b0, b};
            4'd13:   return {1'b0, a};
            default: return {1'b1, a ^ b ^ 4'h5};
        endcase
    endfunction

    assign {bus.alu_cout, bus.alu_f} = force_f ? 5'h0A
                                               : alsu(bus.alu_s, bus.alu_a, bus.alu_b, bus.alu_cin);

    // Drive a command at a negedge; returns at the negedge inside EXEC with cmd_valid low.
    task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic src);
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_cin = cin;
        bus.cmd_src_acc = src;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                @(negedge clk);
                bus.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: cmd_ready got 0 for 20 cycles, required 1");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_cin = 1'b0;
        bus.cmd_src_acc = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready);
        end
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero} !== 7'b0) begin
            n_fail++; $display("FAIL rst_res: got %b %h %b %b want 0 0 0 0",
                               bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero);
        end
        n_tests++;
        if ({bus.acc, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s} !== 17'b0) begin
            n_fail++; $display("FAIL rst_regs: got acc=%h a=%h b=%h cin=%b s=%h want all 0",
                               bus.acc, bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_s);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_basic_add();
        bus.res_ready = 1'b0;
        issue(4'b0000, 4'h1, 4'h2, 1'b0, 1'b0);
        n_tests++;
        if ({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin} !== {4'h1, 4'h2, 4'h0, 1'b0}) begin
            n_fail++; $display("FAIL add_alu_in: got a=%h b=%h s=%h cin=%b want 1 2 0 0",
                               bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin);
        end
        n_tests++;
        if ({bus.cmd_ready, bus.res_valid} !== 2'b00) begin
            n_fail++; $display("FAIL add_exec_flags: got ready=%b valid=%b want 0 0",
                               bus.cmd_ready, bus.res_valid);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc} !==
            {1'b1, 4'h3, 1'b0, 1'b0, 4'h3}) begin
            n_fail++; $display("FAIL add_result: got v=%b d=%h c=%b z=%b acc=%h want 1 3 0 0 3",
                               bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc);
        end
    endtask

    task automatic test_chaining();
        issue(4'b0101, 4'hF, 4'h0, 1'b0, 1'b1);
        n_tests++;
        if (bus.alu_a !== 4'h3) begin
            n_fail++; $display("FAIL chain_alu_a: got %h want 3", bus.alu_a);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.acc, bus.res_data, bus.cmd_ready} !== {4'h4, 4'h3, 1'b0}) begin
            n_fail++; $display("FAIL chain_full: got acc=%h head=%h ready=%b want 4 3 0",
                               bus.acc, bus.res_data, bus.cmd_ready);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.res_data} !== {1'b1, 4'h4}) begin
            n_fail++; $display("FAIL chain_second: got v=%b d=%h want 1 4",
                               bus.res_valid, bus.res_data);
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_tests++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL chain_drained: got valid=%b want 0", bus.res_valid);
        end
    endtask

    task automatic test_carry_zero();
        issue(4'b0000, 4'hF, 4'h1, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({bus.res_data, bus.res_cout, bus.res_zero, bus.acc} !== {4'h0, 1'b1, 1'b1, 4'h0}) begin
            n_fail++; $display("FAIL carry_result: got d=%h c=%b z=%b acc=%h want 0 1 1 0",
                               bus.res_data, bus.res_cout, bus.res_zero, bus.acc);
        end
        force_f = 1'b1;
        issue(4'b1111, 4'h6, 4'h9, 1'b1, 1'b0);
        n_tests++;
        if (bus.alu_s !== 4'hF) begin
            n_fail++; $display("FAIL read_alu_s: got %h want f", bus.alu_s);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc} !==
            {1'b1, 4'h0, 1'b0, 1'b1, 4'h0}) begin
            n_fail++; $display("FAIL read_result: got v=%b d=%h c=%b z=%b acc=%h want 1 0 0 1 0",
                               bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc);
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        force_f = 1'b0;
        n_tests++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL read_drained: got valid=%b want 0", bus.res_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got[$];
        int         accepted;
        logic       acc_now;
        bus.res_ready = 1'b0;
        issue(4'b0000, 4'h1, 4'h2, 1'b0, 1'b0);
        @(negedge clk);
        issue(4'b0101, 4'h0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        bus.cmd_op = 4'b0101;
        bus.cmd_src_acc = 1'b1;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({bus.cmd_ready, bus.acc, bus.alu_a, bus.res_data} !== {1'b0, 4'h4, 4'h3, 4'h3}) begin
                n_fail++;
                $display("FAIL bp_hold: got ready=%b acc=%h alu_a=%h head=%h want 0 4 3 3",
                         bus.cmd_ready, bus.acc, bus.alu_a, bus.res_data);
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.res_valid && bus.res_ready) got.push_back(bus.res_data);
            acc_now = bus.cmd_valid && bus.cmd_ready;
            if (acc_now) accepted++;
            @(negedge clk);
            if (acc_now) bus.cmd_valid = 1'b0;
        end
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        n_tests++;
        if (accepted != 1 || got.size() != 3) begin
            n_fail++; $display("FAIL bp_counts: got accepts=%0d pops=%0d want 1 3",
                               accepted, got.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                n_tests++;
                if (got[i] !== 4'(3 + i)) begin
                    n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], 4'(3 + i));
                end
            end
        end
    endtask

    task automatic test_clr_push_pop();
        bus.res_ready = 1'b0;
        issue(4'b0000, 4'h1, 4'h1, 1'b0, 1'b0);
        @(negedge clk);
        issue(4'b1110, 4'h7, 4'h7, 1'b0, 1'b0);
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.acc} !== {1'b1, 4'h2, 4'h2}) begin
            n_fail++; $display("FAIL clr_pre: got v=%b d=%h acc=%h want 1 2 2",
                               bus.res_valid, bus.res_data, bus.acc);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_tests++;
        if ({bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc} !==
            {1'b1, 4'h0, 1'b0, 1'b1, 4'h0}) begin
            n_fail++; $display("FAIL clr_result: got v=%b d=%h c=%b z=%b acc=%h want 1 0 0 1 0",
                               bus.res_valid, bus.res_data, bus.res_cout, bus.res_zero, bus.acc);
        end
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.cmd_ready} !== 2'b11) begin
            n_fail++; $display("FAIL clr_count_one: got valid=%b ready=%b want 1 1",
                               bus.res_valid, bus.cmd_ready);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        n_tests++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_drained: got valid=%b want 0", bus.res_valid);
        end
    endtask

    task automatic test_reset_mid_exec();
        bus.res_ready = 1'b0;
        issue(4'b0000, 4'h3, 4'h4, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.acc} !== {1'b1, 4'h7}) begin
            n_fail++; $display("FAIL rme_pre: got v=%b acc=%h want 1 7", bus.res_valid, bus.acc);
        end
        issue(4'b0000, 4'h1, 4'h1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({bus.res_valid, bus.acc, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin, bus.cmd_ready}
            !== 19'b0) begin
            n_fail++;
            $display("FAIL rme_in_rst: got v=%b acc=%h a=%h b=%h s=%h cin=%b rdy=%b want all 0",
                     bus.res_valid, bus.acc, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin,
                     bus.cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.cmd_ready, bus.res_valid, bus.acc, bus.res_data} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
            n_fail++; $display("FAIL rme_after: got rdy=%b v=%b acc=%h d=%h want 1 0 0 0",
                               bus.cmd_ready, bus.res_valid, bus.acc, bus.res_data);
        end
    endtask

    // Randomized run: the model keeps a queue of expected {data,cout,zero} in accept order and
    // knows a result appears two negedges after the negedge at which the command was offered.
    task automatic test_random();
        logic [5:0] q[$];
        logic [5:0] h;
        logic [4:0] r;
        logic [3:0] model_acc, acc_vis, acc_pend, src_a, res;
        logic       exp_ready, exp_valid, c;
        int         pend;
        force_f = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        acc_vis = '0;
        acc_pend = '0;
        pend = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) acc_vis = acc_pend;
            end
            exp_valid = (q.size() > ((pend > 0) ? 1 : 0));
            exp_ready = (pend == 0) && (q.size() < 2);
            n_tests++;
            if ({bus.acc, bus.cmd_ready, bus.res_valid} !== {acc_vis, exp_ready, exp_valid}) begin
                n_fail++;
                $display("FAIL rnd_state@%0d: got acc=%h rdy=%b v=%b want %h %b %b", cyc,
                         bus.acc, bus.cmd_ready, bus.res_valid, acc_vis, exp_ready, exp_valid);
            end
            bus.res_ready = ($urandom_range(0, 2) != 0);
            if (exp_valid && bus.res_ready) begin
                h = q.pop_front();
                n_tests++;
                if ({bus.res_data, bus.res_cout, bus.res_zero} !== h) begin
                    n_fail++;
                    $display("FAIL rnd_pop@%0d: got d=%h c=%b z=%b want %h %b %b", cyc,
                             bus.res_data, bus.res_cout, bus.res_zero, h[5:2], h[1], h[0]);
                end
            end
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_op = 4'($urandom_range(0, 15));
            bus.cmd_a = 4'($urandom_range(0, 15));
            bus.cmd_b = 4'($urandom_range(0, 15));
            bus.cmd_cin = 1'($urandom_range(0, 1));
            bus.cmd_src_acc = 1'($urandom_range(0, 1));
            if (bus.cmd_valid && exp_ready) begin
                src_a = bus.cmd_src_acc ? model_acc : bus.cmd_a;
                if (bus.cmd_op == 4'b1110) begin
                    res = 4'h0;
                    c = 1'b0;
                end else if (bus.cmd_op == 4'b1111) begin
                    res = model_acc;
                    c = 1'b0;
                end else begin
                    r = alsu(bus.cmd_op, src_a, bus.cmd_b, bus.cmd_cin);
                    res = r[3:0];
                    c = r[4];
                end
                model_acc = res;
                q.push_back({res, c, (res == 4'h0)});
                acc_pend = model_acc;
                pend = 2;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_chaining();
        test_carry_zero();
        test_backpressure();
        test_clr_push_pop();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
